// File: rtl/bounded_multimode_counter_if.sv
// Control, configuration and status signals of the bounded multimode counter.
// The master side drives the controls and bounds; the slave side (the counter)
// returns the registered count and status flags.
interface bounded_multimode_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              enable;
    logic              flip;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  max;
    logic [WIDTH-1:0]  min;
    logic              direction;
    logic [WIDTH-1:0]  out;
    logic              bound_hit;
    logic              err;

    modport master (
        output enable, flip, load, load_val, mode, step, max, min,
        input  direction, out, bound_hit, err
    );

    modport slave (
        input  enable, flip, load, load_val, mode, step, max, min,
        output direction, out, bound_hit, err
    );
endinterface

// File: rtl/bounded_multimode_counter.sv
// Bounded up/down counter with programmable step and three run modes:
// ping-pong between the bounds, wrap to the opposite bound, or saturate.
// Bounds may change at any time; an out-of-range count freezes the counter
// and raises err until a valid load or a reset recovers it.
module bounded_multimode_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    bounded_multimode_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_PING = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_SAT  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    logic [WIDTH-1:0]  out_q, out_d;
    logic              dir_q, dir_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;

    mode_e             mode;
    logic              cfg_ok;
    logic              load_ok;
    logic              update;
    logic [STEP_W-1:0] step_eff;
    logic [WIDTH:0]    s_ext;
    logic [WIDTH:0]    up_raw;
    logic [WIDTH:0]    dn_raw;
    logic              up_above;    // up_raw > max
    logic              up_at_least; // up_raw >= max
    logic              dn_below;    // dn_raw < min, borrow counts as below
    logic              dn_at_most;  // dn_raw <= min
    logic              d_eff;
    logic [WIDTH-1:0]  next;
    logic              wrapped;

    assign mode = mode_e'(bus.mode);

    // Configuration checks against the current-cycle bounds.
    assign cfg_ok  = (bus.min < bus.max) && (bus.min <= out_q) && (out_q <= bus.max);
    assign load_ok = (bus.min < bus.max) && (bus.min <= bus.load_val)
                     && (bus.load_val <= bus.max);
    assign update  = !bus.load && bus.enable && cfg_ok && (mode != MODE_HOLD);

    // One extra bit on both sums: carry out of up_raw and borrow out of dn_raw
    // are kept so overflow past either end of the range is never lost.
    assign step_eff    = (bus.step == '0) ? STEP_W'(1) : bus.step;
    assign s_ext       = (WIDTH+1)'(step_eff);
    assign up_raw      = {1'b0, out_q} + s_ext;
    assign dn_raw      = {1'b0, out_q} - s_ext;
    assign up_above    = up_raw > {1'b0, bus.max};
    assign up_at_least = up_raw >= {1'b0, bus.max};
    assign dn_below    = dn_raw[WIDTH] || (dn_raw[WIDTH-1:0] < bus.min);
    assign dn_at_most  = dn_raw[WIDTH] || (dn_raw[WIDTH-1:0] <= bus.min);

    // Candidate next count and direction for an update in the active mode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        d_eff   = bus.flip ? ~dir_q : dir_q;
        next    = out_q;
        wrapped = 1'b0;
        unique case (mode)
            MODE_PING: begin
                if (out_q == bus.max)      d_eff = 1'b0;
                else if (out_q == bus.min) d_eff = 1'b1;
                if (d_eff) next = up_at_least ? bus.max : up_raw[WIDTH-1:0];
                else       next = dn_at_most  ? bus.min : dn_raw[WIDTH-1:0];
            end
            MODE_WRAP: begin
                if (d_eff) begin
                    next    = up_above ? bus.min : up_raw[WIDTH-1:0];
                    wrapped = up_above;
                end else begin
                    next    = dn_below ? bus.max : dn_raw[WIDTH-1:0];
                    wrapped = dn_below;
                end
            end
            MODE_SAT: begin
                if (d_eff) next = up_above ? bus.max : up_raw[WIDTH-1:0];
                else       next = dn_below ? bus.min : dn_raw[WIDTH-1:0];
            end
            MODE_HOLD: begin
                d_eff = dir_q;
            end
        endcase
    end

    // Register inputs: load beats enable; otherwise hold with bound_hit low.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        hit_d = 1'b0;
        err_d = !cfg_ok;
        if (bus.load) begin
            if (load_ok) out_d = bus.load_val;
            else         err_d = 1'b1;
        end else if (update) begin
            out_d = next;
            dir_d = d_eff;
            hit_d = wrapped || (next == bus.min) || (next == bus.max);
        end
    end

    // State register with synchronous active-low reset to the lower bound.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            out_q <= bus.min;
            dir_q <= 1'b1;
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            hit_q <= hit_d;
            err_q <= err_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.direction = dir_q;
    assign bus.bound_hit = hit_q;
    assign bus.err       = err_q;

endmodule

// File: doc/bounded_multimode_counter.md
Name: bounded_multimode_counter

Overview:
Parametrised bounded up/down counter. It is the next generation of the team's 4-bit ping-pong counter and adds configurable width, programmable step, three run modes (ping-pong, wrap, saturate), synchronous load, a bound-hit pulse and a configuration-error flag. It is used as a general-purpose sequencing and address counter.

Parameters:
WIDTH, 8, bit width of out, max, min and load_val.
STEP_W, 4, bit width of the step input.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
enable  in  1  advance the counter this cycle.
flip  in  1  invert the current direction for this cycle's update.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value to load.
mode  in  2  run mode: 00 ping-pong, 01 wrap, 10 saturate, 11 hold.
step  in  STEP_W  increment magnitude; 0 is treated as 1.
max  in  WIDTH  upper bound, inclusive, unsigned.
min  in  WIDTH  lower bound, inclusive, unsigned.
direction  out  1  registered direction; 1 = up, 0 = down.
out  out  WIDTH  registered count.
bound_hit  out  1  one-cycle pulse: the last update landed on a bound or wrapped.
err  out  1  registered configuration/range error.

Behaviour:
- Reset, when rst_n == 0 at a clk edge:
  - out <= min (value sampled that cycle); direction <= 1; bound_hit <= 0; err <= 0.
- cfg_ok = (min < max) && (min <= out <= max). This is unsigned and combinational.
- err <= !cfg_ok on every non-reset edge, regardless of enable or load.
- Priority is reset > load > enable. When none applies, out and direction hold and bound_hit <= 0.
- Load (load == 1):
  - Accepted only if min < max and min <= load_val <= max: out <= load_val, direction unchanged, bound_hit <= 0.
  - Otherwise the load is ignored (state holds) and err <= 1 that edge.
  - enable is ignored in a load cycle.
- Enable (enable == 1, load == 0):
  - If !cfg_ok or mode == 11, the counter holds and bound_hit <= 0.
  - Otherwise an update occurs, 1-cycle latency.
- Step and arithmetic:
  - s = (step == 0) ? 1 : step, zero-extended.
  - Sums are computed at WIDTH+1 bits, so there is no silent overflow.
  - up_raw = out + s; dn_raw = out - s, compared signed / with borrow against min.
- Effective direction: d = flip ? ~direction : direction.
- Ping-pong (00):
  - If out == max, d = 0; else if out == min, d = 1. This overrides flip.
  - d == 1: next = (up_raw >= max) ? max : up_raw.
  - d == 0: next = (dn_raw <= min) ? min : dn_raw.
  - direction <= d. The turn happens on the update that starts at a bound.
- Wrap (01):
  - No bound forcing of d.
  - d == 1: next = (up_raw > max) ? min : up_raw.
  - d == 0: next = (dn_raw < min) ? max : dn_raw.
  - Wrap snaps to the opposite bound; there is no modulo carry of the remainder.
  - direction <= d.
- Saturate (10):
  - No bound forcing of d.
  - next is clamped at max or min; the counter sits at the bound until d changes via flip.
  - direction <= d.
- bound_hit <= 1 iff an update occurred and either next is in {min, max} or a wrap occurred.
- Dynamic bounds:
  - max and min may change at any time; the check uses the current-cycle values.
  - If out falls outside the new range, the counter holds and err asserts on the next edge.
  - Recovery is by load or reset only.
- Reset mid-operation overrides load and enable in the same cycle.

Test Plan:
- Ping-pong, WIDTH=8, min=2, max=5, step=1, enable=1 after reset -> out 2,3,4,5,4,3,2,3; direction 1,1,1,1,0,0,0,1; bound_hit high after landing on 5 and 2.
- Ping-pong, step=3, min=0, max=10 -> out 0,3,6,9,10,7,4,1,0,3; direction turns to 0 on leaving 10 and to 1 on leaving 0.
- Wrap, min=3, max=6, step=2, up -> out 3,5,3,5; pulse flip=1 once at out=5 -> next 3; then down with step=2 -> 6 (wrap), 4.
- Saturate, load_val=5, min=2, max=9, flip to down, step=2 -> out 5,3,2,2,2; one flip=1 at out=2 -> 4, and direction stays 1 afterwards.
- Error cases:
  - min=7, max=7 -> out holds and err=1 on the next edge.
  - Restore max=9, then load_val=12 -> load ignored, err=1.
  - load_val=8 -> out=8, err=0.
- step=0 behaves as step=1.
- rst_n=0 asserted together with load=1 and enable=1 mid-count -> out=min, direction=1, bound_hit=0, err=0.
